// File: rtl/link_tx_sync.sv
// rtl/link_tx_sync.sv - clocked valid/ready to dual-rail link transmitter
//
// Converts a synchronous valid/ready word stream into a delay-insensitive
// dual-rail link. Two-phase ("TP") toggles one rail per bit for each word.
// Four-phase ("FP") raises one rail per bit and returns the rails to zero.
//
// Ports:
//   clk       sole clock
//   rst_n     asynchronous active-low reset
//   in_data   word to send (REG_WIDTH bits)
//   in_valid  in_data is valid
//   in_ready  word accepted on a clk edge with in_valid && in_ready
//   err       sticky protocol error (unexpected ack while idle)
//   out_data  link rails, out_data[r][b] = rail r of bit b
//   out_ack   link acknowledge from the receiver (asynchronous)
module link_tx_sync #(
  parameter int REG_WIDTH   = 2,
  parameter     ENC         = "TP",
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [REG_WIDTH-1:0]       in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       err,
  output logic [1:0][REG_WIDTH-1:0]  out_data,
  input  logic                       out_ack
);

  localparam bit IS_FP = (ENC == "FP");

  generate
    if ((ENC != "TP") && (ENC != "FP")) begin : g_bad_enc
      $error("link_tx_sync: ENC must be \"TP\" or \"FP\"");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("link_tx_sync: SYNC_STAGES must be at least 2");
    end
  endgenerate

  // ST_WAIT is the TP wait state and the FP wait-for-ack-high state.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RTZ     = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_t;

  state_t                      r_state;
  logic [SYNC_STAGES-1:0]      r_sync;
  logic                        r_ack_ph;
  logic                        r_err;
  logic [1:0][REG_WIDTH-1:0]   r_data;

  logic                        w_ack_s;
  logic                        w_accept;
  logic [1:0][REG_WIDTH-1:0]   w_hot;

  assign w_ack_s  = r_sync[SYNC_STAGES-1];
  assign in_ready = (r_state == ST_IDLE);
  assign w_accept = in_valid && in_ready;
  assign err      = r_err;
  assign out_data = r_data;

  // One rail per bit selected by the bit value: rail 1 for a one, rail 0 for a zero.
  assign w_hot[1] = in_data;
  assign w_hot[0] = ~in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sync   <= '0;
      r_ack_ph <= 1'b0;
      r_err    <= 1'b0;
      r_data   <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], out_ack};
      case (r_state)
        ST_IDLE: begin
          // An ack while idle is a receiver fault; TP realigns its phase so
          // the next word still completes on the following toggle.
          if (IS_FP) begin
            if (w_ack_s) r_err <= 1'b1;
          end else if (w_ack_s != r_ack_ph) begin
            r_err    <= 1'b1;
            r_ack_ph <= w_ack_s;
          end
          if (w_accept) begin
            r_data  <= IS_FP ? w_hot : (r_data ^ w_hot);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (IS_FP) begin
            if (w_ack_s) begin
              r_data  <= '0;
              r_state <= ST_RTZ;
            end
          end else if (w_ack_s != r_ack_ph) begin
            r_ack_ph <= w_ack_s;
            r_state  <= ST_IDLE;
          end
        end
        // Spacer cycle between clearing the rails and watching for ack low.
        ST_RTZ: r_state <= ST_WAIT_LO;
        ST_WAIT_LO: begin
          if (!w_ack_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
